// File: rtl/exc_pkg.sv
// Shared exception definitions: one-hot bit positions, ECODE values and commit FSM states.
// The CSR file imports the same bit indices so both ends agree on the csr_exc layout.
package exc_pkg;

    localparam int EXC_W = 6;

    localparam int EXC_INT  = 5;
    localparam int EXC_ADEF = 4;
    localparam int EXC_ALE  = 3;
    localparam int EXC_BRK  = 2;
    localparam int EXC_INE  = 1;
    localparam int EXC_SYS  = 0;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    typedef enum logic {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: raw {INT,ADEF,ALE,BRK,INE,SYS} flags to a one-hot vector.
// Order is INT > ADEF > INE > SYS > BRK > ALE; output is zero when no flag is set.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic [EXC_W-1:0] raw,
    output logic [EXC_W-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (raw[EXC_INT])       onehot[EXC_INT]  = 1'b1;
        else if (raw[EXC_ADEF]) onehot[EXC_ADEF] = 1'b1;
        else if (raw[EXC_INE])  onehot[EXC_INE]  = 1'b1;
        else if (raw[EXC_SYS])  onehot[EXC_SYS]  = 1'b1;
        else if (raw[EXC_BRK])  onehot[EXC_BRK]  = 1'b1;
        else if (raw[EXC_ALE])  onehot[EXC_ALE]  = 1'b1;
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Exception/ERTN commit sequencer: pulses the CSR file, flushes the pipe and offers the
// redirect PC to IF over valid/ready, with an interrupt hold-off after each redirect.
module exc_commit_ctrl
    import exc_pkg::*;
#(
    parameter int INT_HOLDOFF = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wb_valid,
    input  logic [31:0]      wb_pc,
    input  logic [4:0]       wb_exc_raw,
    input  logic             wb_ertn,
    input  logic [31:0]      wb_vaddr,
    input  logic             has_int,
    input  logic [31:0]      csr_eentry_pc,
    input  logic [31:0]      csr_eertn_pc,
    output logic [EXC_W-1:0] csr_exc,
    output logic             csr_ertn_flush,
    output logic [31:0]      csr_wb_pc,
    output logic [31:0]      csr_fault_va,
    output logic             pipe_flush,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    input  logic             redir_ready,
    output logic             busy,
    output logic [CNT_W-1:0] exc_count
);

    localparam int HO_W = (INT_HOLDOFF > 0) ? $clog2(INT_HOLDOFF + 1) : 1;

    state_t            state_reg;
    logic              redir_valid_reg;
    logic [31:0]       redir_pc_reg;
    logic [HO_W-1:0]   holdoff_reg;
    logic [CNT_W-1:0]  exc_count_reg;

    logic              int_ok;
    logic [EXC_W-1:0]  exc_raw6;
    logic [EXC_W-1:0]  exc_sel;
    logic              exc_hit;
    logic              take;

    assign int_ok   = has_int & (holdoff_reg == '0);
    assign exc_raw6 = {int_ok, wb_exc_raw};

    exc_prio_enc u_prio (
        .raw    (exc_raw6),
        .onehot (exc_sel)
    );

    assign exc_hit = |exc_sel;
    assign take    = resetn & (state_reg == IDLE) & wb_valid & (exc_hit | wb_ertn);

    // Every output except the two passthroughs reads as zero while resetn is low.
    assign csr_exc        = take ? exc_sel : '0;
    assign csr_ertn_flush = take & ~exc_hit;
    assign pipe_flush     = take | (resetn & (state_reg == REDIR));
    assign redir_valid    = resetn & redir_valid_reg;
    assign redir_pc       = resetn ? redir_pc_reg : 32'd0;
    assign busy           = resetn & (state_reg != IDLE);
    assign exc_count      = resetn ? exc_count_reg : '0;
    assign csr_wb_pc      = wb_pc;
    assign csr_fault_va   = wb_vaddr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg       <= IDLE;
            redir_valid_reg <= 1'b0;
            redir_pc_reg    <= 32'd0;
            holdoff_reg     <= '0;
            exc_count_reg   <= '0;
        end else begin
            if (holdoff_reg != '0) begin
                holdoff_reg <= holdoff_reg - 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (take) begin
                        state_reg       <= REDIR;
                        redir_valid_reg <= 1'b1;
                        // ERA is read here, before the CSR file applies the ERTN update.
                        redir_pc_reg    <= exc_hit ? csr_eentry_pc : csr_eertn_pc;
                        exc_count_reg   <= exc_count_reg + CNT_W'(1);
                    end
                end
                REDIR: begin
                    if (redir_valid_reg && redir_ready) begin
                        state_reg       <= IDLE;
                        redir_valid_reg <= 1'b0;
                        holdoff_reg     <= HO_W'(INT_HOLDOFF);
                    end
                end
                default: begin
                    state_reg       <= IDLE;
                    redir_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: directed vectors, corner sequences and a
// randomized run against a cycle-level reference model of the commit rules.
module tb_exc_commit_ctrl;

    localparam int HOLDOFF = 2;
    localparam int CW      = 8;

    logic            clk;
    logic            resetn;
    logic            wb_valid;
    logic [31:0]     wb_pc;
    logic [4:0]      wb_exc_raw;
    logic            wb_ertn;
    logic [31:0]     wb_vaddr;
    logic            has_int;
    logic [31:0]     csr_eentry_pc;
    logic [31:0]     csr_eertn_pc;
    logic [5:0]      csr_exc;
    logic            csr_ertn_flush;
    logic [31:0]     csr_wb_pc;
    logic [31:0]     csr_fault_va;
    logic            pipe_flush;
    logic            redir_valid;
    logic [31:0]     redir_pc;
    logic            redir_ready;
    logic            busy;
    logic [CW-1:0]   exc_count;

    exc_commit_ctrl #(.INT_HOLDOFF(HOLDOFF), .CNT_W(CW)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .wb_valid       (wb_valid),
        .wb_pc          (wb_pc),
        .wb_exc_raw     (wb_exc_raw),
        .wb_ertn        (wb_ertn),
        .wb_vaddr       (wb_vaddr),
        .has_int        (has_int),
        .csr_eentry_pc  (csr_eentry_pc),
        .csr_eertn_pc   (csr_eertn_pc),
        .csr_exc        (csr_exc),
        .csr_ertn_flush (csr_ertn_flush),
        .csr_wb_pc      (csr_wb_pc),
        .csr_fault_va   (csr_fault_va),
        .pipe_flush     (pipe_flush),
        .redir_valid    (redir_valid),
        .redir_pc       (redir_pc),
        .redir_ready    (redir_ready),
        .busy           (busy),
        .exc_count      (exc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: waiting-for-IF flag, latched target, hold-off cycles left, commit count.
    bit          m_busy;
    logic [31:0] m_pc;
    int          m_hold;
    int unsigned m_count;
    int          prio[6] = '{5, 4, 1, 0, 2, 3};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic calc(output logic [5:0] e, output logic f, output logic tk);
        logic [5:0] flags;
        e  = '0;
        f  = 1'b0;
        tk = 1'b0;
        flags = {has_int && (m_hold == 0), wb_exc_raw};
        if (!m_busy && wb_valid) begin
            for (int k = 0; k < 6; k++) begin
                if (e == 0 && flags[prio[k]]) e = 6'd1 << prio[k];
            end
            f  = (e == 0) && wb_ertn;
            tk = (e != 0) || f;
        end
    endtask

    task automatic cmp_model();
        logic [5:0] e;
        logic f, tk;
        calc(e, f, tk);
        if (!resetn) begin
            chk("rst_exc", csr_exc, 0);
            chk("rst_ertn", csr_ertn_flush, 0);
            chk("rst_flush", pipe_flush, 0);
            chk("rst_rvalid", redir_valid, 0);
            chk("rst_rpc", redir_pc, 0);
            chk("rst_busy", busy, 0);
            chk("rst_count", exc_count, 0);
        end else begin
            chk("m_exc", csr_exc, e);
            chk("m_ertn", csr_ertn_flush, f);
            chk("m_flush", pipe_flush, tk || m_busy);
            chk("m_rvalid", redir_valid, m_busy);
            chk("m_rpc", redir_pc, m_pc);
            chk("m_busy", busy, m_busy);
            chk("m_count", exc_count, m_count);
        end
        chk("m_wbpc", csr_wb_pc, wb_pc);
        chk("m_va", csr_fault_va, wb_vaddr);
    endtask

    task automatic model_update();
        logic [5:0] e;
        logic f, tk;
        if (!resetn) begin
            m_busy = 0; m_pc = 0; m_hold = 0; m_count = 0;
        end else begin
            calc(e, f, tk);
            if (m_hold > 0) m_hold--;
            if (!m_busy && tk) begin
                m_busy  = 1;
                m_pc    = (e != 0) ? csr_eentry_pc : csr_eertn_pc;
                m_count = (m_count + 1) % (1 << CW);
            end else if (m_busy && redir_ready) begin
                m_busy = 0;
                m_hold = HOLDOFF;
            end
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled mid-cycle.
    task automatic half();
        #4;
    endtask

    task automatic fin();
        cmp_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        wb_valid = 0; wb_exc_raw = 0; wb_ertn = 0; has_int = 0; redir_ready = 0;
        repeat (n) begin half(); fin(); end
    endtask

    typedef struct {
        logic       hint;
        logic [4:0] raw;
        logic       ertn;
        logic [5:0] exp_exc;
        logic       exp_flush;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] saved_pc;
        int unsigned saved_cnt;

        vecs[0]  = '{1'b0, 5'b00001, 1'b0, 6'b000001, 1'b0};
        vecs[1]  = '{1'b1, 5'b11010, 1'b0, 6'b100000, 1'b0};
        vecs[2]  = '{1'b0, 5'b11010, 1'b0, 6'b010000, 1'b0};
        vecs[3]  = '{1'b0, 5'b01010, 1'b0, 6'b000010, 1'b0};
        vecs[4]  = '{1'b0, 5'b01001, 1'b0, 6'b000001, 1'b0};
        vecs[5]  = '{1'b0, 5'b01100, 1'b0, 6'b000100, 1'b0};
        vecs[6]  = '{1'b0, 5'b01000, 1'b0, 6'b001000, 1'b0};
        vecs[7]  = '{1'b0, 5'b00000, 1'b1, 6'b000000, 1'b1};
        vecs[8]  = '{1'b0, 5'b00100, 1'b1, 6'b000100, 1'b0};
        vecs[9]  = '{1'b1, 5'b00000, 1'b1, 6'b100000, 1'b0};
        vecs[10] = '{1'b0, 5'b00011, 1'b0, 6'b000010, 1'b0};
        vecs[11] = '{1'b0, 5'b10100, 1'b0, 6'b010000, 1'b0};

        resetn = 0; wb_valid = 0; wb_pc = 32'h1c000100; wb_exc_raw = 0; wb_ertn = 0;
        wb_vaddr = 32'h0000_1235; has_int = 0; csr_eentry_pc = 32'h1c008000;
        csr_eertn_pc = 32'h1c000104; redir_ready = 0;
        m_busy = 0; m_pc = 0; m_hold = 0; m_count = 0;
        @(posedge clk); model_update(); #1;
        half(); fin();
        resetn = 1;
        half();
        chk("reset_busy", busy, 0);
        chk("reset_count", exc_count, 0);
        chk("reset_rvalid", redir_valid, 0);
        fin();

        // SYS commit, one-cycle redirect latency, then handshake.
        wb_valid = 1; wb_exc_raw = 5'b00001;
        half();
        chk("t1_exc", csr_exc, 6'b000001);
        chk("t1_flush", pipe_flush, 1);
        chk("t1_rvalid_take", redir_valid, 0);
        fin();
        wb_valid = 0; wb_exc_raw = 0; redir_ready = 1;
        half();
        chk("t1_rvalid", redir_valid, 1);
        chk("t1_rpc", redir_pc, 32'h1c008000);
        chk("t1_exc_redir", csr_exc, 0);
        fin();
        redir_ready = 0;
        half();
        chk("t1_busy", busy, 0);
        chk("t1_count", exc_count, 1);
        fin();
        $display("seq sys_commit: count=%0d", exc_count);
        idle(3);

        for (int i = 0; i < 12; i++) begin
            wb_valid = 1; has_int = vecs[i].hint; wb_exc_raw = vecs[i].raw; wb_ertn = vecs[i].ertn;
            half();
            chk("vec_exc", csr_exc, vecs[i].exp_exc);
            chk("vec_ertn", csr_ertn_flush, vecs[i].exp_flush);
            chk("vec_flush", pipe_flush, 1);
            fin();
            wb_valid = 0; has_int = 0; wb_exc_raw = 0; wb_ertn = 0; redir_ready = 1;
            half();
            chk("vec_rpc", redir_pc, (vecs[i].exp_exc != 0) ? 32'h1c008000 : 32'h1c000104);
            fin();
            $display("vec %0d: int=%0b raw=%05b ertn=%0b exc=%06b ertn_flush=%0b",
                     i, vecs[i].hint, vecs[i].raw, vecs[i].ertn, vecs[i].exp_exc, vecs[i].exp_flush);
            idle(3);
        end

        // IF stalls the redirect for 5 cycles while WB keeps presenting SYS.
        wb_valid = 1; wb_exc_raw = 5'b00001; csr_eentry_pc = 32'h1c00a000;
        half(); fin();
        saved_pc = 32'h1c00a000; saved_cnt = m_count;
        csr_eentry_pc = 32'h1c008000;
        repeat (5) begin
            half();
            chk("t4_rvalid", redir_valid, 1);
            chk("t4_rpc", redir_pc, saved_pc);
            chk("t4_exc", csr_exc, 0);
            chk("t4_count", exc_count, saved_cnt);
            fin();
        end
        redir_ready = 1; wb_valid = 0; wb_exc_raw = 0;
        half(); fin();
        $display("seq stalled_redirect: rpc=%08h", saved_pc);
        idle(3);

        // Interrupt held through the handshake is ignored for HOLDOFF cycles.
        wb_valid = 1; wb_exc_raw = 5'b00001;
        half(); fin();
        wb_exc_raw = 0; has_int = 1; redir_ready = 1;
        half(); fin();
        redir_ready = 0;
        half(); chk("t5_hold1", csr_exc, 0); fin();
        half(); chk("t5_hold2", csr_exc, 0); fin();
        half(); chk("t5_int", csr_exc, 6'b100000); fin();
        has_int = 0; wb_valid = 0; redir_ready = 1;
        half(); fin();
        $display("seq int_holdoff: done");
        idle(3);

        // Reset while a redirect is outstanding.
        wb_valid = 1; wb_exc_raw = 5'b00001;
        half(); fin();
        wb_valid = 0; wb_exc_raw = 0; resetn = 0;
        half(); fin();
        resetn = 1;
        half();
        chk("t6_rvalid", redir_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_count", exc_count, 0);
        fin();
        $display("seq reset_in_redir: done");

        // Counter wrap at 2^CW-1.
        for (int n = 0; n < (1 << CW); n++) begin
            wb_valid = 1; wb_exc_raw = 5'b00001; redir_ready = 0;
            half(); fin();
            wb_valid = 0; wb_exc_raw = 0; redir_ready = 1;
            half(); fin();
            if (n == (1 << CW) - 2) begin
                half(); chk("wrap_max", exc_count, (1 << CW) - 1); fin();
            end
        end
        redir_ready = 0;
        half(); chk("wrap_zero", exc_count, 0); fin();
        $display("seq count_wrap: done");

        for (int i = 0; i < 3000; i++) begin
            resetn        = ($urandom_range(0, 99) != 0);
            wb_valid      = $urandom_range(0, 1);
            wb_pc         = $urandom;
            wb_vaddr      = $urandom;
            wb_exc_raw    = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
            wb_ertn       = ($urandom_range(0, 3) == 0);
            has_int       = ($urandom_range(0, 2) == 0);
            csr_eentry_pc = $urandom;
            csr_eertn_pc  = $urandom;
            redir_ready   = $urandom_range(0, 1);
            half(); fin();
        end
        $display("random: 3000 cycles, model count=%0d", m_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
